nonsynth_ethernet_mii_sender: RTL

Simulation-only MII frame generator that drives the MII receive pins of the Ethernet receiver under test. A testbench loads a frame into a word-addressed buffer. The block then serializes it onto a 4-bit MII bus as preamble, SFD, payload, zero padding and CRC-32 FCS, followed by the inter-frame gap. It is the direct upstream stage of the receiver: its `mii_*_o` outputs connect to the receiver's `mii_rxd_i` / `mii_rx_dv_i` / `mii_rx_er_i`.

---
 rtl/nonsynth_ethernet_mii_sender.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/nonsynth_ethernet_mii_sender.sv
// nonsynth_ethernet_mii_sender
// MII frame generator for driving an Ethernet receiver under test. A word
// buffer is loaded while idle. A send then serializes preamble, SFD, payload,
// zero padding to 60 bytes and the CRC-32 FCS onto a 4-bit MII bus. The
// inter-frame gap follows the frame.
// Optional feature macro: NONSYNTH_ETH_SENDER_ERR_INJECT_EN adds err_inject_i.
// When it is set at send time, that frame gets a corrupted FCS (bit 0
// flipped) and a one-nibble mii_tx_er_o pulse on the first DATA nibble.
module nonsynth_ethernet_mii_sender #(
  parameter int send_width_p  = 8,
  parameter int buf_size_p    = 1560,
  parameter int ifg_cycles_p  = 24,
  parameter int addr_width_lp = $clog2(buf_size_p/send_width_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_v_i,
  input  logic [addr_width_lp-1:0] wr_addr_i,
  input  logic [63:0]              wr_data_i,
  input  logic [15:0]              packet_size_i,
  input  logic                     send_v_i,
`ifdef NONSYNTH_ETH_SENDER_ERR_INJECT_EN
  input  logic                     err_inject_i,
`endif
  output logic                     send_ready_o,
  output logic                     done_o,
  output logic [3:0]               mii_txd_o,
  output logic                     mii_tx_en_o,
  output logic                     mii_tx_er_o
);

  localparam int          words_lp   = buf_size_p / send_width_p;
  localparam logic [15:0] buf_len_lp = 16'(buf_size_p);
  localparam logic [15:0] min_len_lp = 16'd60;
  localparam logic [15:0] ifg_lp     = 16'(ifg_cycles_p);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_FCS, S_IFG} state_t;

  // Only 8-byte buffer words are supported; complain every clock otherwise.
  if (send_width_p != 8) begin : g_width_chk
    always @(posedge clk_i) $error("send_width_p must be 8");
  end

  // One nibble step of the reflected CRC-32.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'h0, d};
    for (int i = 0; i < 4; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] byte_cnt;
  logic        hi;
  logic [15:0] len_r, eff_r;
  logic [31:0] crc;
  logic [27:0] fcs_sr;
  logic        err_r;

  logic [63:0] mem [words_lp];

  logic [15:0] len_in, eff_in;
  logic [63:0] rd_word;
  logic [7:0]  cur_byte;
  logic [3:0]  nib;
  logic [31:0] fcs_val;
  logic        accept;

  assign accept   = send_v_i && send_ready_o && (len_in != 16'd0);
  assign len_in   = (packet_size_i > buf_len_lp) ? buf_len_lp : packet_size_i;
  assign eff_in   = (len_in < min_len_lp) ? min_len_lp : len_in;
  assign rd_word  = mem[byte_cnt[3 +: addr_width_lp]];
  // Bytes past the loaded length read as zero padding.
  assign cur_byte = (byte_cnt < len_r) ? rd_word[{byte_cnt[2:0], 3'b000} +: 8] : 8'h00;
  assign nib      = hi ? cur_byte[7:4] : cur_byte[3:0];
  assign fcs_val  = ~crc ^ {31'h0, err_r};

`ifdef NONSYNTH_ETH_SENDER_ERR_INJECT_EN
  // Error-inject request is captured with the send handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     err_r <= 1'b0;
    else if (accept) err_r <= err_inject_i;
  end
`else
  assign err_r = 1'b0;
`endif

  // Buffer writes are only honoured while idle; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_v_i && send_ready_o) mem[wr_addr_i] <= wr_data_i;
  end

  // Frame FSM: state names the nibble currently on the bus; each edge
  // registers the next nibble so all outputs come straight from flops.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      send_ready_o <= 1'b1;
      done_o       <= 1'b0;
      mii_txd_o    <= 4'h0;
      mii_tx_en_o  <= 1'b0;
      mii_tx_er_o  <= 1'b0;
      cnt          <= 16'd0;
      byte_cnt     <= 16'd0;
      hi           <= 1'b0;
      len_r        <= 16'd0;
      eff_r        <= 16'd0;
      crc          <= 32'hFFFFFFFF;
      fcs_sr       <= 28'h0;
    end else begin
      done_o      <= 1'b0;
      mii_tx_er_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state        <= S_PRE;
            send_ready_o <= 1'b0;
            mii_tx_en_o  <= 1'b1;
            mii_txd_o    <= 4'h5;
            cnt          <= 16'd1;
            len_r        <= len_in;
            eff_r        <= eff_in;
            byte_cnt     <= 16'd0;
            hi           <= 1'b0;
            crc          <= 32'hFFFFFFFF;
          end
        end
        S_PRE: begin
          if (cnt == 16'd15) begin
            state     <= S_SFD;
            mii_txd_o <= 4'hD;
          end else begin
            mii_txd_o <= 4'h5;
            cnt       <= cnt + 16'd1;
          end
        end
        S_SFD: begin
          // First payload nibble: low half of byte 0.
          state       <= S_DATA;
          mii_txd_o   <= nib;
          crc         <= crc_nib(crc, nib);
          hi          <= 1'b1;
          mii_tx_er_o <= err_r;
        end
        S_DATA: begin
          if (byte_cnt == eff_r) begin
            state     <= S_FCS;
            mii_txd_o <= fcs_val[3:0];
            fcs_sr    <= fcs_val[31:4];
            cnt       <= 16'd1;
          end else begin
            mii_txd_o <= nib;
            crc       <= crc_nib(crc, nib);
            if (hi) begin
              hi       <= 1'b0;
              byte_cnt <= byte_cnt + 16'd1;
            end else begin
              hi <= 1'b1;
            end
          end
        end
        S_FCS: begin
          if (cnt == 16'd8) begin
            state       <= S_IFG;
            mii_tx_en_o <= 1'b0;
            mii_txd_o   <= 4'h0;
            done_o      <= 1'b1;
            cnt         <= 16'd1;
          end else begin
            mii_txd_o <= fcs_sr[3:0];
            fcs_sr    <= {4'h0, fcs_sr[27:4]};
            cnt       <= cnt + 16'd1;
          end
        end
        S_IFG: begin
          if (cnt == ifg_lp) begin
            state        <= S_IDLE;
            send_ready_o <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
